// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side memory responder.
// Holds the FSM state encoding, default tohost constants and the byte-lane merge.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'd84;
    localparam logic [31:0] PASS_VALUE_DEFAULT  = 32'd7;

    // Lanes with be[i] set take new_word, the rest keep old_word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM: synchronous byte-enabled write, combinational read, no reset.
// Read and write share one word address.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= be_merge(mem[addr], wdata, be);
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states, error checking and a tohost
// register that turns the core's final store into sticky done/pass outputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT        = 2,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
    parameter logic [31:0] PASS_VALUE  = PASS_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        done,
    output logic        pass,
    output dmem_state_t fsm_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and rsp_valid is a one-cycle
    // strobe with no backpressure.

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_CNT  = 4'(WAIT);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] tohost_q;
    logic        done_q;
    logic        pass_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        commit;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [3:0]  op_be;
    logic        op_err;
    logic        op_tohost;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge itself, so the
    // operation comes straight from the request inputs instead of the capture regs.
    assign op_we    = (state_q == S_IDLE) ? req_we    : cap_we;
    assign op_addr  = (state_q == S_IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata : cap_wdata;
    assign op_be    = (state_q == S_IDLE) ? req_be    : cap_be;

    assign op_err    = (op_addr[1:0] != 2'b00) ||
                       ((op_addr >= RAM_BYTES) && (op_addr != TOHOST_ADDR));
    assign op_tohost = !op_err && (op_addr == TOHOST_ADDR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_d == S_RESP) && (state_q != S_RESP) && !reset;
    assign ram_we = commit && op_we && !op_err && !op_tohost;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (op_addr[AW+1:2]),
        .wdata(op_wdata),
        .be   (op_be),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            tohost_q  <= 32'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                cnt_q     <= WAIT_CNT;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_we) ? 32'd0 :
                           (op_tohost ? tohost_q : ram_rdata);
                if (op_we && op_tohost) begin
                    tohost_q <= op_wdata;
                    if (!done_q) begin
                        done_q <= 1'b1;
                        pass_q <= (op_wdata == PASS_VALUE);
                    end
                end
            end else begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fsm_state = state_q;

endmodule
